output_stage_buffered: RTL and testbench
========================================

Name: output_stage_buffered

Overview:
Parametrised successor of the cipher output stage. Buffers keystream/cipher bytes from the output holder in a small FIFO and presents them on the chip output pins one at a time. Uses a level-based ready/acknowledge handshake toward the chip user. Sits between the output holder and the chip pins; reports back-pressure, fill level and overflow to the interface FSM.

Parameters:
DATA_W, 8, width of each output word
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of the fill-level output

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  output holder presents a word this cycle
in_data  input  DATA_W  word from output holder
in_ready  output  1  FIFO can accept a word (input_acknowledged to interface FSM)
flush  input  1  synchronous clear of FIFO, output register and error flag
output_acknowledge  input  1  chip user has read data_out (level, already synchronised)
data_out  output  DATA_W  word presented to chip pins
output_byte_is_ready  output  1  data_out valid; held until acknowledged
fill_level  output  CNT_W  words in FIFO (excludes word in output register)
overflow_err  output  1  sticky: write attempted while full

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers 0, fill_level=0, data_out=0, output_byte_is_ready=0, overflow_err=0, state O_EMPTY. in_ready=1 once rst deasserts.
- Write side: in_ready = !full, purely combinational from the registered count. Push occurs when in_valid && in_ready.
- Write side, full: in_ready=0 even if a pop happens the same cycle; no same-cycle push-through when full.
- Overflow: in_valid && !in_ready sets overflow_err; the word is dropped. overflow_err is cleared only by flush or rst.
- Read FSM states: O_EMPTY, O_READY, O_WAIT_RELEASE.
- O_EMPTY: if FIFO non-empty, pop the head into the data_out register and go to O_READY. output_byte_is_ready=0.
- O_READY: output_byte_is_ready=1 and data_out is stable. When output_acknowledge=1, go to O_WAIT_RELEASE.
- O_WAIT_RELEASE: output_byte_is_ready=0. Wait for output_acknowledge=0, then go to O_EMPTY. A held-high ack consumes exactly one word.
- Latency: a word pushed at edge N into an empty FIFO with state O_EMPTY is loaded at edge N+1. output_byte_is_ready is high after edge N+1.
- Back-to-back: a release followed by the next load costs one cycle in O_EMPTY.
- Simultaneous push and pop on the same edge: fill_level is unchanged, pointers both advance.
- data_out keeps its last value in O_EMPTY/O_WAIT_RELEASE; it changes only on a load.
- Pointer wrap: pointers are log2(DEPTH) bits with natural wrap. Full/empty derive from the count register, range 0..DEPTH.
- flush (synchronous, priority over push/pop/ack): clears pointers, count, overflow_err and output_byte_is_ready; state to O_EMPTY. data_out is left unchanged. A push in the same cycle is discarded and does not set overflow_err.
- Reset mid-handshake: returns immediately to reset values. A pending ack after reset is treated as a release in O_EMPTY and has no effect.

Decomposition:
- types_pkg: add output_stage_state_t enum {O_EMPTY, O_READY, O_WAIT_RELEASE}, replacing use of output_holder_state_t for this block.
- Sub-module sync_fifo: parameters DATA_W and DEPTH; ports push, pop, wdata, rdata, count, full, empty; async active-high reset.
- output_stage_buffered holds the FSM, output register and error flag.

Test Plan:
1. Reset then single word: push 0xA5 at cycle 2 -> output_byte_is_ready=1 with data_out=0xA5 after edge 3. Ack high 5 cycles -> exactly one word consumed, then ready=0 until ack drops.
2. Fill: push 0x01..0x05 with ack held low -> 0x01 in output register, fill_level=4, in_ready=0.
3. Overflow: continue from scenario 2 and push 0x06 -> overflow_err=1 and 0x06 dropped. Drain with ack pulses -> sequence 0x01,0x02,0x03,0x04,0x05.
4. Wrap-around: 12 words 0x10..0x1B with interleaved push/ack -> output order preserved; simultaneous push+pop keeps fill_level constant.
5. Flush in O_READY with 3 words queued -> next cycle ready=0, fill_level=0, overflow_err=0, data_out unchanged. Flush coincident with a push -> word discarded.
6. Async reset asserted mid O_WAIT_RELEASE, between clock edges -> all outputs at reset values immediately. Next push loads normally with 2-cycle latency.

Source files
------------

// File: rtl/types_pkg.sv
// Shared type definitions for the cipher output path.
// Holds the read-side state encoding of the buffered output stage.
package types_pkg;

  typedef enum logic [1:0] {
    O_EMPTY        = 2'd0,
    O_READY        = 2'd1,
    O_WAIT_RELEASE = 2'd2
  } output_stage_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a count register and synchronous clear.
// Ports: push/pop/wdata in, rdata/count/full/empty out; clr empties it.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !clr;
  assign pop_ok  = pop && !empty && !clr;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/output_stage_buffered.sv
// Buffered cipher output stage: FIFO feeding a level-handshake output register.
// Ports: in_valid/in_data/in_ready from holder, data_out/ready/ack to pins, status.
module output_stage_buffered
  import types_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  input  logic              output_acknowledge,
  output logic [DATA_W-1:0] data_out,
  output logic              output_byte_is_ready,
  output logic [CNT_W-1:0]  fill_level,
  output logic              overflow_err
);

  output_stage_state_t state, state_nxt;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] rdata;

  // in_ready comes from the registered count only; a pop on the
  // same edge never frees a slot for a push-through.
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (state == O_EMPTY) && !empty && !flush;

  assign output_byte_is_ready = (state == O_READY);

  sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .push (push),
    .pop  (pop),
    .wdata(in_data),
    .rdata(rdata),
    .count(fill_level),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      O_EMPTY:        if (!empty) state_nxt = O_READY;
      O_READY:        if (output_acknowledge) state_nxt = O_WAIT_RELEASE;
      O_WAIT_RELEASE: if (!output_acknowledge) state_nxt = O_EMPTY;
      default:        state_nxt = O_EMPTY;
    endcase
    if (flush) state_nxt = O_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= O_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // data_out only moves on a load, so it survives flush and release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (pop) begin
      data_out <= rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (flush) begin
      overflow_err <= 1'b0;
    end else if (in_valid && !in_ready) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_output_stage_buffered.sv
// Self-checking bench for output_stage_buffered.
// Directed scenarios plus randomized traffic against a queue model.
module tb_output_stage_buffered;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              output_acknowledge = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] data_out;
  logic              output_byte_is_ready;
  logic [CNT_W-1:0]  fill_level;
  logic              overflow_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] mq [$];
  bit         m_pres;
  bit         m_rel;
  bit         m_ovf;
  logic [7:0] m_word;
  bit         last_push;
  bit         last_load;

  output_stage_buffered #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .flush               (flush),
    .output_acknowledge  (output_acknowledge),
    .data_out            (data_out),
    .output_byte_is_ready(output_byte_is_ready),
    .fill_level          (fill_level),
    .overflow_err        (overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset;
    mq.delete();
    m_pres = 0;
    m_rel  = 0;
    m_ovf  = 0;
    m_word = '0;
  endtask

  // Advance one clock edge and apply the same edge to the model:
  // a word is presented until an ack is seen, then the pins must
  // see the ack drop before the next word is taken from the queue.
  task automatic tick;
    bit acc;
    bit ld;
    @(posedge clk);
    acc = 0;
    ld  = 0;
    if (flush) begin
      mq.delete();
      m_pres = 0;
      m_rel  = 0;
      m_ovf  = 0;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      if (in_valid && !acc) m_ovf = 1;
      ld = !m_pres && !m_rel && (mq.size() > 0);
      if (m_pres && output_acknowledge) begin
        m_pres = 0;
        m_rel  = 1;
      end else if (m_rel && !output_acknowledge) begin
        m_rel = 0;
      end
      if (ld) begin
        m_word = mq.pop_front();
        m_pres = 1;
      end
      if (acc) mq.push_back(in_data);
    end
    last_push = acc;
    last_load = ld;
    #1;
  endtask

  task automatic test_reset;
    model_reset();
    #2;
    total_cnt++;
    if ({output_byte_is_ready, data_out, fill_level, overflow_err}
        !== {1'b0, 8'h00, 3'd0, 1'b0}) begin
      $display("FAIL reset_vals: rdy=%0b data=%02h fill=%0d ovf=%0b, want 0/00/0/0",
               output_byte_is_ready, data_out, fill_level, overflow_err);
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end else pass_cnt++;
  endtask

  task automatic test_single;
    in_valid = 1;
    in_data  = 8'hA5;
    tick();
    in_valid = 0;
    total_cnt++;
    if ({output_byte_is_ready, fill_level} !== {1'b0, 3'd1}) begin
      $display("FAIL single_pre: rdy=%0b fill=%0d, want 0/1",
               output_byte_is_ready, fill_level);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({output_byte_is_ready, data_out, fill_level} !== {1'b1, 8'hA5, 3'd0}) begin
      $display("FAIL single_load: rdy=%0b data=%02h fill=%0d, want 1/a5/0",
               output_byte_is_ready, data_out, fill_level);
    end else pass_cnt++;
    in_valid = 1;
    in_data  = 8'h5A;
    tick();
    in_valid = 0;
    output_acknowledge = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({output_byte_is_ready, data_out, fill_level} !== {1'b0, 8'hA5, 3'd1}) begin
        $display("FAIL ack_held[%0d]: rdy=%0b data=%02h fill=%0d, want 0/a5/1",
                 i, output_byte_is_ready, data_out, fill_level);
      end else pass_cnt++;
    end
    output_acknowledge = 0;
    tick();
    total_cnt++;
    if (output_byte_is_ready !== 1'b0) begin
      $display("FAIL release_gap: rdy=%0b want 0", output_byte_is_ready);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({output_byte_is_ready, data_out, fill_level} !== {1'b1, 8'h5A, 3'd0}) begin
      $display("FAIL second_load: rdy=%0b data=%02h fill=%0d, want 1/5a/0",
               output_byte_is_ready, data_out, fill_level);
    end else pass_cnt++;
    output_acknowledge = 1;
    tick();
    output_acknowledge = 0;
    tick();
    tick();
  endtask

  task automatic test_fill_overflow;
    int w;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1;
      in_data  = 8'(k);
      tick();
    end
    in_valid = 0;
    total_cnt++;
    if ({output_byte_is_ready, data_out, fill_level, in_ready}
        !== {1'b1, 8'h01, 3'd4, 1'b0}) begin
      $display("FAIL fill: rdy=%0b data=%02h fill=%0d in_ready=%0b, want 1/01/4/0",
               output_byte_is_ready, data_out, fill_level, in_ready);
    end else pass_cnt++;
    in_valid = 1;
    in_data  = 8'h06;
    tick();
    in_valid = 0;
    total_cnt++;
    if ({overflow_err, fill_level} !== {1'b1, 3'd4}) begin
      $display("FAIL overflow: ovf=%0b fill=%0d, want 1/4",
               overflow_err, fill_level);
    end else pass_cnt++;
    for (int k = 1; k <= 5; k++) begin
      w = 0;
      while (!output_byte_is_ready && w < 10) begin
        tick();
        w++;
      end
      total_cnt++;
      if ({output_byte_is_ready, data_out} !== {1'b1, 8'(k)}) begin
        $display("FAIL drain[%0d]: rdy=%0b data=%02h, want 1/%02h",
                 k, output_byte_is_ready, data_out, k);
      end else pass_cnt++;
      output_acknowledge = 1;
      tick();
      output_acknowledge = 0;
      tick();
    end
    tick();
    total_cnt++;
    if ({output_byte_is_ready, fill_level, overflow_err} !== {1'b0, 3'd0, 1'b1}) begin
      $display("FAIL drained: rdy=%0b fill=%0d ovf=%0b, want 0/0/1",
               output_byte_is_ready, fill_level, overflow_err);
    end else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [7:0] got [$];
    int sent;
    int coinc;
    logic [CNT_W-1:0] fill_prev;
    flush = 1;
    tick();
    flush = 0;
    sent  = 0;
    coinc = 0;
    for (int c = 0; c < 300 && got.size() < 12; c++) begin
      if (output_byte_is_ready && !output_acknowledge) begin
        got.push_back(data_out);
        output_acknowledge = 1;
      end else begin
        output_acknowledge = 0;
      end
      in_valid  = (sent < 12) && in_ready && ($urandom_range(0, 3) != 0);
      in_data   = 8'(8'h10 + sent);
      fill_prev = fill_level;
      tick();
      if (last_push) sent++;
      total_cnt++;
      if (fill_level !== 3'(mq.size())) begin
        $display("FAIL wrap_fill: got %0d want %0d", fill_level, mq.size());
      end else pass_cnt++;
      if (last_push && last_load) begin
        coinc++;
        total_cnt++;
        if (fill_level !== fill_prev) begin
          $display("FAIL push_pop_fill: got %0d want %0d", fill_level, fill_prev);
        end else pass_cnt++;
      end
    end
    in_valid = 0;
    output_acknowledge = 0;
    total_cnt++;
    if (got.size() != 12) begin
      $display("FAIL wrap_count: got %0d words want 12", got.size());
    end else pass_cnt++;
    for (int i = 0; i < got.size(); i++) begin
      total_cnt++;
      if (got[i] !== 8'(8'h10 + i)) begin
        $display("FAIL wrap_order[%0d]: got %02h want %02h", i, got[i], 8'h10 + i);
      end else pass_cnt++;
    end
    if (coinc == 0) $display("note: no push+pop coincidence seen in wrap");
    tick();
    tick();
  endtask

  task automatic test_flush;
    flush = 1;
    tick();
    flush = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1;
      in_data  = 8'(8'h21 + k);
      tick();
    end
    in_valid = 0;
    total_cnt++;
    if ({output_byte_is_ready, data_out, fill_level} !== {1'b1, 8'h21, 3'd3}) begin
      $display("FAIL flush_setup: rdy=%0b data=%02h fill=%0d, want 1/21/3",
               output_byte_is_ready, data_out, fill_level);
    end else pass_cnt++;
    flush    = 1;
    in_valid = 1;
    in_data  = 8'h77;
    tick();
    flush    = 0;
    in_valid = 0;
    total_cnt++;
    if ({output_byte_is_ready, data_out, fill_level, overflow_err}
        !== {1'b0, 8'h21, 3'd0, 1'b0}) begin
      $display("FAIL flush_ready: rdy=%0b data=%02h fill=%0d ovf=%0b, want 0/21/0/0",
               output_byte_is_ready, data_out, fill_level, overflow_err);
    end else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if ({output_byte_is_ready, fill_level, data_out} !== {1'b0, 3'd0, 8'h21}) begin
      $display("FAIL flush_discard: rdy=%0b fill=%0d data=%02h, want 0/0/21",
               output_byte_is_ready, fill_level, data_out);
    end else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1;
      in_data  = 8'(8'h30 + k);
      tick();
    end
    in_valid = 0;
    total_cnt++;
    if ({overflow_err, data_out} !== {1'b1, 8'h30}) begin
      $display("FAIL flush_ovf_pre: ovf=%0b data=%02h, want 1/30",
               overflow_err, data_out);
    end else pass_cnt++;
    flush = 1;
    tick();
    flush = 0;
    total_cnt++;
    if ({overflow_err, fill_level, output_byte_is_ready} !== {1'b0, 3'd0, 1'b0}) begin
      $display("FAIL flush_ovf_clr: ovf=%0b fill=%0d rdy=%0b, want 0/0/0",
               overflow_err, fill_level, output_byte_is_ready);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    in_valid = 1;
    in_data  = 8'h44;
    tick();
    in_valid = 0;
    tick();
    output_acknowledge = 1;
    in_valid = 1;
    in_data  = 8'h45;
    tick();
    in_valid = 0;
    total_cnt++;
    if ({output_byte_is_ready, data_out, fill_level} !== {1'b0, 8'h44, 3'd1}) begin
      $display("FAIL mid_setup: rdy=%0b data=%02h fill=%0d, want 0/44/1",
               output_byte_is_ready, data_out, fill_level);
    end else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({output_byte_is_ready, data_out, fill_level, overflow_err, in_ready}
        !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1}) begin
      $display("FAIL mid_reset: rdy=%0b data=%02h fill=%0d ovf=%0b inr=%0b, want 0/00/0/0/1",
               output_byte_is_ready, data_out, fill_level, overflow_err, in_ready);
    end else pass_cnt++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1;
    in_data  = 8'h3C;
    tick();
    in_valid = 0;
    total_cnt++;
    if ({output_byte_is_ready, fill_level} !== {1'b0, 3'd1}) begin
      $display("FAIL post_reset_push: rdy=%0b fill=%0d, want 0/1",
               output_byte_is_ready, fill_level);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({output_byte_is_ready, data_out} !== {1'b1, 8'h3C}) begin
      $display("FAIL post_reset_load: rdy=%0b data=%02h, want 1/3c",
               output_byte_is_ready, data_out);
    end else pass_cnt++;
    tick();
    output_acknowledge = 0;
    tick();
  endtask

  task automatic test_random;
    for (int c = 0; c < 800; c++) begin
      flush    = ($urandom_range(0, 31) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      output_acknowledge = $urandom_range(0, 1) != 0;
      tick();
      total_cnt++;
      if ({data_out, output_byte_is_ready, fill_level, in_ready, overflow_err}
          !== {m_word, m_pres, 3'(mq.size()), (mq.size() < DEPTH), m_ovf}) begin
        $display("FAIL random[%0d]: data=%02h rdy=%0b fill=%0d inr=%0b ovf=%0b, want %02h/%0b/%0d/%0b/%0b",
                 c, data_out, output_byte_is_ready, fill_level, in_ready, overflow_err,
                 m_word, m_pres, mq.size(), mq.size() < DEPTH, m_ovf);
      end else pass_cnt++;
    end
    flush = 0;
    in_valid = 0;
    output_acknowledge = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
